// File: rtl/data_memory_if.sv
// Load/store bus between the integer datapath and the data memory.
// DM_SUBWORD_EN adds the dm_size access-size field.
`timescale 1ns/1ps
interface data_memory_if;
  logic        dm_cs;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] Address;
  logic [31:0] D_In;
  logic [31:0] D_Out;
  logic        dm_ready;
  logic        dm_err;
`ifdef DM_SUBWORD_EN
  logic [1:0]  dm_size;
`endif

  // Handshake: the master raises dm_cs with dm_rd/dm_wr/Address/D_In valid and
  // keeps it high until dm_ready (one-cycle pulse, dm_err valid alongside), then
  // drops dm_cs for at least one cycle before the next request.
  modport master (
    output
`ifdef DM_SUBWORD_EN
           dm_size,
`endif
           dm_cs, dm_rd, dm_wr, Address, D_In,
    input  D_Out, dm_ready, dm_err
  );

  modport slave (
    input
`ifdef DM_SUBWORD_EN
           dm_size,
`endif
           dm_cs, dm_rd, dm_wr, Address, D_In,
    output D_Out, dm_ready, dm_err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Wait-stated, byte-addressed, big-endian data memory with a 4-phase cs/ready handshake.
// Define DM_SUBWORD_EN to enable byte/halfword accesses via dm_size.
`timescale 1ns/1ps
module data_memory_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset,
  data_memory_if.slave     bus,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2, S_HOLD = 2'd3} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          data_q;
  logic                 rd_q, wr_q, err_q;
  logic [1:0]           size_q;
  logic [31:0]          dout_q;

  logic [7:0] mem [0:(1<<ADDR_BITS)-1];

  logic                 live_err;
  logic [1:0]           live_size;
  logic [ADDR_BITS-1:0] cur_addr, a1, a2, a3;
  logic [31:0]          cur_data, rd_data;
  logic                 cur_rd, cur_wr, cur_err;
  logic [1:0]           cur_size;
  logic                 commit;

  wire unused_addr_hi = &{1'b0, bus.Address[31:ADDR_BITS]};

`ifdef DM_SUBWORD_EN
  assign live_size = bus.dm_size;
  always_comb begin
    live_err = (bus.dm_rd == bus.dm_wr);
    case (bus.dm_size)
      2'b00:   live_err = live_err | (bus.Address[1:0] != 2'b00);
      2'b01:   live_err = live_err | bus.Address[0];
      2'b10:   live_err = live_err;
      default: live_err = 1'b1;
    endcase
  end
`else
  assign live_size = 2'b00;
  assign live_err  = (bus.dm_rd == bus.dm_wr) | (bus.Address[1:0] != 2'b00);
`endif

  // With zero wait states the commit lands on the accept edge, so use the live request there.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_addr = bus.Address[ADDR_BITS-1:0];
      cur_data = bus.D_In;
      cur_rd   = bus.dm_rd;
      cur_wr   = bus.dm_wr;
      cur_err  = live_err;
      cur_size = live_size;
    end else begin
      cur_addr = addr_q;
      cur_data = data_q;
      cur_rd   = rd_q;
      cur_wr   = wr_q;
      cur_err  = err_q;
      cur_size = size_q;
    end
  end

  assign a1 = cur_addr + ADDR_BITS'(1);
  assign a2 = cur_addr + ADDR_BITS'(2);
  assign a3 = cur_addr + ADDR_BITS'(3);

  always_comb begin
    case (cur_size)
      2'b01:   rd_data = {16'h0000, mem[cur_addr], mem[a1]};
      2'b10:   rd_data = {24'h000000, mem[cur_addr]};
      default: rd_data = {mem[cur_addr], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.dm_cs) begin
        cnt_d   = 4'd0;
        state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) state_d = S_ACK;
        else                              cnt_d   = cnt_q + 4'd1;
      end
      S_ACK:  state_d = S_HOLD;
      S_HOLD: if (!bus.dm_cs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = (state_q != S_ACK) && (state_d == S_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && bus.dm_cs) begin
        addr_q <= bus.Address[ADDR_BITS-1:0];
        data_q <= bus.D_In;
        rd_q   <= bus.dm_rd;
        wr_q   <= bus.dm_wr;
        err_q  <= live_err;
        size_q <= live_size;
      end
      if (commit && cur_rd && !cur_err) dout_q <= rd_data;
    end
  end

  // Memory contents survive reset; reset only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_wr && !cur_err) begin
      case (cur_size)
        2'b01: begin
          mem[cur_addr] <= cur_data[15:8];
          mem[a1]       <= cur_data[7:0];
        end
        2'b10: mem[cur_addr] <= cur_data[7:0];
        default: begin
          mem[cur_addr] <= cur_data[31:24];
          mem[a1]       <= cur_data[23:16];
          mem[a2]       <= cur_data[15:8];
          mem[a3]       <= cur_data[7:0];
        end
      endcase
    end
  end

  assign bus.D_Out    = dout_q;
  assign bus.dm_ready = (state_q == S_ACK);
  assign bus.dm_err   = (state_q == S_ACK) && err_q;
  assign dbg_state    = state_q;
endmodule
